io_arbiter: RTL and testbench
=============================

IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, meaning data width per requester, equal to the uo_out width.
REQ-003 SHALL have parameter MAX_BEATS, default 16, meaning the maximum valid beats per grant before forced release.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, design-selected enable; low blocks new grants.
REQ-007 SHALL have port req, input, N, per-requester request/valid level.
REQ-008 SHALL have port req_last, input, N, per-requester final-beat marker, sampled only with req.
REQ-009 SHALL have port req_data, input, N*W, requester i data in bits [i*W +: W].
REQ-010 SHALL have port gnt, output, N, registered one-hot grant, zero when no owner.
REQ-011 SHALL have port gnt_id, output, clog2(N), index of current owner, held at last owner when gnt is zero.
REQ-012 SHALL have port out_data, output, W, muxed owner data; zero when out_valid low.
REQ-013 SHALL have port out_valid, output, 1, high when a beat transfers this cycle.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, GAP, state registered.
REQ-016 SHALL, in IDLE or GAP with ena=1 and req!=0, select the winner by round-robin from pointer ptr upward with wrap from N-1 to 0, and register gnt/gnt_id/state=GRANT at the next edge.
REQ-017 SHALL, in IDLE or GAP with ena=0 or req==0, go to IDLE with gnt=0.
REQ-018 SHALL drive out_valid = (state==GRANT) & req[gnt_id] combinationally; out_data = req_data of gnt_id when out_valid, else 0.
REQ-019 SHALL count valid beats in an internal counter cleared at each new grant, width clog2(MAX_BEATS+1).
REQ-020 SHALL release the grant (next state GAP, gnt=0, ptr=gnt_id+1 mod N) when any of: valid beat with req_last[gnt_id]=1; req[gnt_id]=0 in GRANT (drop); valid beat making the count equal MAX_BEATS; ena=0.
REQ-021 SHALL pulse timeout for the one cycle after a release caused only by the MAX_BEATS limit (req_last not set on that beat).
REQ-022 SHALL hold GAP exactly one cycle with gnt=0 and out_valid=0, giving a minimum one-cycle turnaround between owners.
REQ-023 SHALL ignore req_last, req_data of non-owners; a requester changing req while not granted has no effect beyond arbitration.
REQ-024 SHALL give the same requester a back-to-back grant after GAP only if no other requester is asserted (ptr advanced past it).
REQ-025 SHALL keep gnt one-hot or zero at all times.

Reset
REQ-026 SHALL on rst_n=0 immediately force state=IDLE, gnt=0, gnt_id=0, ptr=0, beat count=0, timeout=0; out_valid and out_data thus 0.
REQ-027 SHALL, on reset mid-grant, abandon the burst with no further beats and resume arbitration from ptr=0 after rst_n rises.

Verification
REQ-028 Single burst: req=0001, 3 beats data 0x11,0x22,0x33, req_last on 3rd -> gnt=0001 one cycle after req, out_valid 3 cycles with those values, then GAP, gnt=0.
REQ-029 Round-robin: req=1111 held, each requester 1-beat bursts with req_last -> grants 0,1,2,3,0 each separated by one GAP cycle.
REQ-030 Timeout: req=0100 held, req_last=0 -> exactly 16 valid beats, timeout=1 one cycle, then gnt=0100 again only if no other req.
REQ-031 Drop and ena: owner deasserts req mid-burst -> GAP next cycle, no timeout; ena=0 during grant -> release, no new grant until ena=1.
REQ-032 Async reset mid-burst: rst_n low between edges -> gnt, out_valid 0 immediately; after release req=1000 and 0001 both -> grant 0001 first.

Source files
------------

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin arbiter granting one of N requesters a burst of
// beats at a time, with a one-cycle turnaround gap between owners and a
// forced release after MAX_BEATS valid beats.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ena               enable; low blocks new grants and releases the owner
//   req, req_last     per-requester valid level and final-beat marker
//   req_data          requester i data in bits [i*W +: W]
//   gnt, gnt_id       registered one-hot grant and owner index (held when idle)
//   out_valid         a beat transfers this cycle (combinational)
//   out_data          owner data while out_valid, else zero (combinational)
//   timeout           one-cycle pulse after a MAX_BEATS forced release
module io_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_last,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic                 timeout
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state, state_d;
  logic [N-1:0]  gnt_d;
  logic [IW-1:0] gnt_id_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [CW-1:0] beat_cnt, beat_cnt_d;
  logic          timeout_d;

  logic [IW-1:0] hi_idx, lo_idx, win;
  logic          hi_found;
  logic [W-1:0]  owner_data;
  logic          beat, last_beat, limit_beat, drop, release_c;
  logic [IW-1:0] ptr_next;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_idx   = IW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  // Owner data select.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id == IW'(i)) owner_data = req_data[i*W +: W];
    end
  end

  assign beat       = (state == GRANT) & req[gnt_id];
  assign last_beat  = beat & req_last[gnt_id];
  assign limit_beat = beat & (beat_cnt == CW'(MAX_BEATS - 1));
  assign drop       = (state == GRANT) & ~req[gnt_id];
  assign release_c  = last_beat | limit_beat | drop | ~ena;
  assign ptr_next   = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);

  assign out_valid = beat;
  assign out_data  = beat ? owner_data : '0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    ptr_d      = ptr;
    beat_cnt_d = beat_cnt;
    timeout_d  = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (ena && (req != '0)) begin
          state_d    = GRANT;
          gnt_id_d   = win;
          beat_cnt_d = '0;
          for (int i = 0; i < N; i++) gnt_d[i] = (win == IW'(i));
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (beat) beat_cnt_d = beat_cnt + CW'(1);
        if (release_c) begin
          state_d   = GAP;
          gnt_d     = '0;
          ptr_d     = ptr_next;
          // Only a pure beat-limit release counts as a timeout.
          timeout_d = limit_beat & ~last_beat & ena;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      ptr      <= ptr_d;
      beat_cnt <= beat_cnt_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: table-driven checks of io_arbiter (N=4, W=8, MAX_BEATS=16)
// plus a hand-written asynchronous-reset sequence.
module tb_io_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  io_arbiter #(.N(4), .W(8), .MAX_BEATS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .out_data (out_data),
    .out_valid(out_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs applied for the cycle, outputs observed mid-cycle.
  typedef struct {
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  gid;
    logic        ov;
    logic [7:0]  od;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] DATA = 32'hD3C2B1A0;

  function automatic void add(logic e, logic [3:0] r, logic [3:0] l, logic [31:0] d,
                              logic [3:0] g, logic [1:0] id, logic ov, logic [7:0] od,
                              logic to);
    vec_t v;
    v.ena = e; v.req = r; v.last = l; v.data = d;
    v.gnt = g; v.gid = id; v.ov = ov; v.od = od; v.to = to;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] g, logic [1:0] id, logic ov,
                         logic [7:0] od, logic to);
    chk({tag, " gnt"},       32'(gnt), 32'(g));
    chk({tag, " gnt_id"},    32'(gnt_id), 32'(id));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_data"},  32'(out_data), 32'(od));
    chk({tag, " timeout"},   32'(timeout), 32'(to));
    chk({tag, " onehot"},    32'($onehot0(gnt)), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round robin from ptr=0: grants 0,1,2,3,0 with one GAP between.
    add(1, 4'b1111, 4'b1111, DATA, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0001, 0, 1, 8'hA0, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0010, 1, 1, 8'hB1, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0000, 1, 0, 8'h00, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0100, 2, 1, 8'hC2, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0000, 2, 0, 8'h00, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b1000, 3, 1, 8'hD3, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0000, 3, 0, 8'h00, 0);
    add(1, 4'b1111, 4'b1111, DATA, 4'b0001, 0, 1, 8'hA0, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0000, 0, 0, 8'h00, 0);
    // Single burst from requester 0: beats 11,22,33, last on the third.
    add(1, 4'b0001, 4'b0000, 32'h11, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b0001, 4'b0000, 32'h11, 4'b0001, 0, 1, 8'h11, 0);
    add(1, 4'b0001, 4'b0000, 32'h22, 4'b0001, 0, 1, 8'h22, 0);
    add(1, 4'b0001, 4'b0001, 32'h33, 4'b0001, 0, 1, 8'h33, 0);
    add(1, 4'b0000, 4'b0000, 32'h00, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b0000, 4'b0000, 32'h00, 4'b0000, 0, 0, 8'h00, 0);
    // Timeout: requester 2 held without last -> 16 beats, pulse, regrant.
    add(1, 4'b0100, 4'b0000, DATA, 4'b0000, 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) add(1, 4'b0100, 4'b0000, DATA, 4'b0100, 2, 1, 8'hC2, 0);
    add(1, 4'b0100, 4'b0000, DATA, 4'b0000, 2, 0, 8'h00, 1);
    add(1, 4'b0101, 4'b0100, DATA, 4'b0100, 2, 1, 8'hC2, 0);
    // ptr now past 2 -> requester 0 wins; it drops immediately, no timeout.
    add(1, 4'b0101, 4'b0000, DATA, 4'b0000, 2, 0, 8'h00, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0001, 0, 0, 8'h00, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0000, 0, 0, 8'h00, 0);
    // ena low during grant releases; no new grant until ena returns.
    add(1, 4'b0010, 4'b0000, DATA, 4'b0000, 0, 0, 8'h00, 0);
    add(1, 4'b0010, 4'b0000, DATA, 4'b0010, 1, 1, 8'hB1, 0);
    add(0, 4'b0010, 4'b0000, DATA, 4'b0010, 1, 1, 8'hB1, 0);
    add(0, 4'b0010, 4'b0000, DATA, 4'b0000, 1, 0, 8'h00, 0);
    add(0, 4'b0010, 4'b0000, DATA, 4'b0000, 1, 0, 8'h00, 0);
    add(1, 4'b0010, 4'b0000, DATA, 4'b0000, 1, 0, 8'h00, 0);
    add(1, 4'b0010, 4'b0010, DATA, 4'b0010, 1, 1, 8'hB1, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0000, 1, 0, 8'h00, 0);
    // Drop mid-burst by requester 3.
    add(1, 4'b1000, 4'b0000, DATA, 4'b0000, 1, 0, 8'h00, 0);
    add(1, 4'b1000, 4'b0000, DATA, 4'b1000, 3, 1, 8'hD3, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b1000, 3, 0, 8'h00, 0);
    add(1, 4'b0000, 4'b0000, DATA, 4'b0000, 3, 0, 8'h00, 0);

    rst_n = 1'b0; ena = 1'b1; req = '0; req_last = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 4'b0000, 0, 0, 8'h00, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      ena = vecs[k].ena; req = vecs[k].req; req_last = vecs[k].last; req_data = vecs[k].data;
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].gid, vecs[k].ov, vecs[k].od, vecs[k].to);
      @(posedge clk); #1;
    end

    // Async reset mid-burst; ptr is 1 beforehand so a surviving ptr would pick 3.
    ena = 1'b1; req = 4'b0001; req_last = 4'b0001; req_data = DATA;
    @(posedge clk); #1;
    @(negedge clk) chk_all("rst_pre_g0", 4'b0001, 0, 1, 8'hA0, 0);
    @(posedge clk); #1;
    req = 4'b1000; req_last = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk) chk_all("rst_pre_g3", 4'b1000, 3, 1, 8'hD3, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_all("rst_async", 4'b0000, 0, 0, 8'h00, 0);
    req = 4'b1001;
    @(posedge clk); #1 chk_all("rst_hold", 4'b0000, 0, 0, 8'h00, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) chk_all("rst_after", 4'b0001, 0, 1, 8'hA0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
